// File: rtl/battleship_pkg.sv
// Shared battleship definitions: grid geometry, placer FSM state codes and
// the flat cell-index helper used by the placer and its cell checker.
package battleship_pkg;

    localparam int GRID_N = 5;
    localparam int CELLS  = GRID_N * GRID_N;
    localparam int IDX_W  = 5;

    // Placer FSM state codes, kept as plain constants for legacy consumers.
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SAMPLE = 3'd1;
    localparam logic [2:0] ST_CHECK  = 3'd2;
    localparam logic [2:0] ST_PLACE  = 3'd3;
    localparam logic [2:0] ST_SCAN   = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        SAMPLE = ST_SAMPLE,
        CHECK  = ST_CHECK,
        PLACE  = ST_PLACE,
        SCAN   = ST_SCAN,
        DONE   = ST_DONE
    } placer_state_t;

    // Flat cell index i*n + j; the product is formed at 32 bits and only
    // then truncated to the index width.
    function automatic logic [IDX_W-1:0] cell_idx(input logic [2:0] i,
                                                  input logic [2:0] j,
                                                  input int unsigned n = GRID_N);
        int unsigned full;
        full = i * n + j;
        return full[IDX_W-1:0];
    endfunction

endpackage

// File: rtl/placer_cell_check.sv
// Combinational accept/reject decision for one candidate cell.
// Optional feature macro: PLACER_ADJ_GUARD_EN (also reject a cell whose
// up/down/left/right neighbour is already occupied).
module placer_cell_check #(
    parameter int GRID_N = 5
) (
    input  logic [2:0]               cand_i,
    input  logic [2:0]               cand_j,
    input  logic [GRID_N*GRID_N-1:0] board_occ,
    output logic                     accept
);
    import battleship_pkg::*;

    localparam int N_CELLS = GRID_N * GRID_N;

    // Occupancy of cell k; indices past the grid read as empty.
    function automatic logic occ_at(input logic [N_CELLS-1:0] occ,
                                    input logic [IDX_W-1:0]   k);
        return (int'(k) < N_CELLS) ? occ[k] : 1'b0;
    endfunction

    logic in_range;
    logic occupied;
    logic adj_hit;

    // Range, occupancy and (optionally) neighbour tests for the candidate.
    always_comb begin
        // NOTE: every signal gets a default before any condition, so no latch is inferred.
        in_range = (int'(cand_i) < GRID_N) && (int'(cand_j) < GRID_N);
        occupied = occ_at(board_occ, cell_idx(cand_i, cand_j, GRID_N));
        adj_hit  = 1'b0;
`ifdef PLACER_ADJ_GUARD_EN
        if (cand_i != 3'd0 &&
            occ_at(board_occ, cell_idx(cand_i - 3'd1, cand_j, GRID_N)))
            adj_hit = 1'b1;
        if (int'(cand_i) < GRID_N - 1 &&
            occ_at(board_occ, cell_idx(cand_i + 3'd1, cand_j, GRID_N)))
            adj_hit = 1'b1;
        if (cand_j != 3'd0 &&
            occ_at(board_occ, cell_idx(cand_i, cand_j - 3'd1, GRID_N)))
            adj_hit = 1'b1;
        if (int'(cand_j) < GRID_N - 1 &&
            occ_at(board_occ, cell_idx(cand_i, cand_j + 3'd1, GRID_N)))
            adj_hit = 1'b1;
`endif
        accept = in_range && !occupied && !adj_hit;
    end

endmodule

// File: rtl/cpu_ship_placer.sv
// CPU board setup: places 1-cell ships from random draws, falling back to a
// row-major scan after RETRY_LIMIT consecutive rejected draws.
// Optional feature macro: PLACER_ADJ_GUARD_EN (adjacency guard, in the checker).
module cpu_ship_placer #(
    parameter int GRID_N      = 5,
    parameter int MAX_SHIPS   = 5,
    parameter int RETRY_LIMIT = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [2:0]               num_ships,
    input  logic [2:0]               rand_i,
    input  logic [2:0]               rand_j,
    output logic                     busy,
    output logic                     done,
    output logic                     place_valid,
    output logic [2:0]               place_i,
    output logic [2:0]               place_j,
    output logic [GRID_N*GRID_N-1:0] board_occ,
    output logic [2:0]               ships_placed
);
    import battleship_pkg::*;

    localparam int RW = $clog2(RETRY_LIMIT + 1);

    logic [2:0]    state;
    logic [2:0]    target;
    logic [2:0]    cand_i, cand_j;
    logic [2:0]    scan_i, scan_j;
    logic [RW-1:0] retry;
    logic [2:0]    target_req;
    logic [2:0]    chk_i, chk_j;
    logic          accept;
    logic          scan_last;

    // Requested count clamped to MAX_SHIPS, and the cell fed to the shared checker.
    always_comb begin
        target_req = (num_ships > 3'(MAX_SHIPS)) ? 3'(MAX_SHIPS) : num_ships;
        chk_i      = (state == ST_SCAN) ? scan_i : cand_i;
        chk_j      = (state == ST_SCAN) ? scan_j : cand_j;
        scan_last  = (scan_i == 3'(GRID_N - 1)) && (scan_j == 3'(GRID_N - 1));
    end

    placer_cell_check #(.GRID_N(GRID_N)) u_check (
        .cand_i    (chk_i),
        .cand_j    (chk_j),
        .board_occ (board_occ),
        .accept    (accept)
    );

    // Placement sequencer: draw, check, place, fallback scan, completion.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
        if (!rst) begin
            state        <= ST_IDLE;
            target       <= '0;
            cand_i       <= '0;
            cand_j       <= '0;
            scan_i       <= '0;
            scan_j       <= '0;
            retry        <= '0;
            board_occ    <= '0;
            ships_placed <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        target       <= target_req;
                        board_occ    <= '0;
                        ships_placed <= '0;
                        retry        <= '0;
                        scan_i       <= '0;
                        scan_j       <= '0;
                        state        <= (target_req == 3'd0) ? ST_DONE : ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    cand_i <= rand_i;
                    cand_j <= rand_j;
                    state  <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (accept) begin
                        state <= ST_PLACE;
                    end else begin
                        retry <= retry + 1'b1;
                        if (retry == RW'(RETRY_LIMIT - 1)) begin
                            scan_i <= '0;
                            scan_j <= '0;
                            state  <= ST_SCAN;
                        end else begin
                            state <= ST_SAMPLE;
                        end
                    end
                end
                ST_SCAN: begin
                    if (accept) begin
                        cand_i <= scan_i;
                        cand_j <= scan_j;
                        state  <= ST_PLACE;
                    end else if (scan_last) begin
                        state <= ST_DONE;
                    end else if (scan_j == 3'(GRID_N - 1)) begin
                        scan_j <= '0;
                        scan_i <= scan_i + 3'd1;
                    end else begin
                        scan_j <= scan_j + 3'd1;
                    end
                end
                ST_PLACE: begin
                    board_occ[cell_idx(cand_i, cand_j, GRID_N)] <= 1'b1;
                    ships_placed <= ships_placed + 3'd1;
                    retry        <= '0;
                    state        <= (ships_placed + 3'd1 == target) ? ST_DONE : ST_SAMPLE;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Status and placement strobes decode directly from the current state.
    always_comb begin
        busy        = (state != ST_IDLE);
        done        = (state == ST_DONE);
        place_valid = (state == ST_PLACE);
        place_i     = place_valid ? cand_i : 3'd0;
        place_j     = place_valid ? cand_j : 3'd0;
    end

endmodule

// File: tb/tb_cpu_ship_placer.sv
// Self-checking bench for cpu_ship_placer: per-cycle random draws are fed to
// the DUT and a transaction-level model predicts every placement, its cycle,
// the completion cycle and the final board.
module tb_cpu_ship_placer;

    localparam int N     = 5;
    localparam int CELLS = N * N;
    localparam int MAXS  = 5;
    localparam int LIM   = 8;
    localparam int MAXC  = 512;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [2:0]       num_ships;
    logic [2:0]       rand_i;
    logic [2:0]       rand_j;
    logic             busy;
    logic             done;
    logic             place_valid;
    logic [2:0]       place_i;
    logic [2:0]       place_j;
    logic [CELLS-1:0] board_occ;
    logic [2:0]       ships_placed;

    cpu_ship_placer #(.GRID_N(N), .MAX_SHIPS(MAXS), .RETRY_LIMIT(LIM)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .num_ships    (num_ships),
        .rand_i       (rand_i),
        .rand_j       (rand_j),
        .busy         (busy),
        .done         (done),
        .place_valid  (place_valid),
        .place_i      (place_i),
        .place_j      (place_j),
        .board_occ    (board_occ),
        .ships_placed (ships_placed)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Random draw presented during cycle c of a run (start is cycle 0).
    int arr_i [MAXC];
    int arr_j [MAXC];

    // Model predictions.
    bit               exp_pv [MAXC];
    int               exp_pi [MAXC];
    int               exp_pj [MAXC];
    int               exp_done_c;
    int               exp_count;
    bit               m_occ [CELLS];
    logic [CELLS-1:0] exp_board;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_ok(input int i, input int j);
        if (i >= N || j >= N) return 1'b0;
        if (m_occ[i*N + j]) return 1'b0;
`ifdef PLACER_ADJ_GUARD_EN
        if (i > 0     && m_occ[(i-1)*N + j]) return 1'b0;
        if (i < N - 1 && m_occ[(i+1)*N + j]) return 1'b0;
        if (j > 0     && m_occ[i*N + j - 1]) return 1'b0;
        if (j < N - 1 && m_occ[i*N + j + 1]) return 1'b0;
`endif
        return 1'b1;
    endfunction

    task automatic model_place(input int c, input int i, input int j);
        exp_pv[c]    = 1'b1;
        exp_pi[c]    = i;
        exp_pj[c]    = j;
        m_occ[i*N+j] = 1'b1;
    endtask

    // Walk the run at the level of draws and scans: a draw taken at cycle t
    // is judged at t+1, an accepted draw is placed at t+2, a rejected one
    // costs 2 cycles, a scan tests one cell per cycle.
    task automatic build_model(input int n);
        int tgt, t, retry, placed, s;
        bit finished;
        for (int c = 0; c < MAXC; c++) begin
            exp_pv[c] = 1'b0;
            exp_pi[c] = 0;
            exp_pj[c] = 0;
        end
        for (int k = 0; k < CELLS; k++) m_occ[k] = 1'b0;
        tgt        = (n > MAXS) ? MAXS : n;
        placed     = 0;
        retry      = 0;
        t          = 1;
        exp_done_c = 1;
        finished   = (tgt == 0);
        while (!finished) begin
            if (model_ok(arr_i[t], arr_j[t])) begin
                model_place(t + 2, arr_i[t], arr_j[t]);
                placed++;
                retry = 0;
                t += 3;
            end else begin
                retry++;
                if (retry < LIM) begin
                    t += 2;
                end else begin
                    retry = 0;
                    s     = t + 2;
                    t     = -1;
                    for (int k = 0; k < CELLS; k++) begin
                        if (t < 0 && model_ok(k / N, k % N)) begin
                            model_place(s + k + 1, k / N, k % N);
                            placed++;
                            t = s + k + 2;
                        end
                    end
                    if (t < 0) begin
                        exp_done_c = s + CELLS;
                        finished   = 1'b1;
                    end
                end
            end
            if (!finished && placed == tgt) begin
                exp_done_c = t;
                finished   = 1'b1;
            end
        end
        exp_count = placed;
        for (int k = 0; k < CELLS; k++) exp_board[k] = m_occ[k];
    endtask

    task automatic fill_const(input int i, input int j);
        for (int c = 0; c < MAXC; c++) begin
            arr_i[c] = i;
            arr_j[c] = j;
        end
    endtask

    // mode 0: mostly on-grid; mode 1: tiny range, many collisions; mode 2: full 0..7.
    task automatic fill_rand(input int mode);
        for (int c = 0; c < MAXC; c++) begin
            case (mode)
                0: begin
                    arr_i[c] = ($urandom_range(0, 9) == 0) ? $urandom_range(5, 7) : $urandom_range(0, 4);
                    arr_j[c] = $urandom_range(0, 4);
                end
                1: begin
                    arr_i[c] = $urandom_range(0, 1);
                    arr_j[c] = $urandom_range(0, 1);
                end
                default: begin
                    arr_i[c] = $urandom_range(0, 7);
                    arr_j[c] = $urandom_range(0, 7);
                end
            endcase
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"},         busy,         '0);
        check({tag, "_done"},         done,         '0);
        check({tag, "_place_valid"},  place_valid,  '0);
        check({tag, "_place_i"},      place_i,      '0);
        check({tag, "_place_j"},      place_j,      '0);
        check({tag, "_ships_placed"}, ships_placed, '0);
        check({tag, "_board_occ"},    board_occ,    '0);
    endtask

    task automatic drive_start(input int n);
        @(negedge clk);
        num_ships = 3'(n);
        start     = 1'b1;
        rand_i    = 3'(arr_i[0]);
        rand_j    = 3'(arr_j[0]);
    endtask

    // One full run, compared cycle by cycle; with noise set, extra start
    // pulses and num_ships changes are applied while the run is busy.
    task automatic run_game(input int n, input bit noise);
        build_model(n);
        drive_start(n);
        for (int c = 1; c <= exp_done_c + 1; c++) begin
            @(negedge clk);
            check("busy",        busy,        32'(c <= exp_done_c));
            check("done",        done,        32'(c == exp_done_c));
            check("place_valid", place_valid, 32'(exp_pv[c]));
            if (exp_pv[c]) begin
                check("place_i", place_i, exp_pi[c]);
                check("place_j", place_j, exp_pj[c]);
            end
            if (c == exp_done_c) begin
                check("board_occ",    board_occ,    exp_board);
                check("ships_placed", ships_placed, exp_count);
            end
            if (c == exp_done_c + 1) begin
                check("board_hold",  board_occ,    exp_board);
                check("placed_hold", ships_placed, exp_count);
            end
            start     = noise && (c <= exp_done_c) && ($urandom_range(0, 3) == 0);
            num_ships = 3'($urandom_range(0, 7));
            rand_i    = 3'(arr_i[c]);
            rand_j    = 3'(arr_j[c]);
        end
        start = 1'b0;
    endtask

    // Reset during the second placement, then rebuild from an empty board.
    task automatic run_reset_mid();
        int seen;
        seen = 0;
        fill_rand(0);
        build_model(7);
        drive_start(7);
        for (int c = 1; c <= exp_done_c && seen < 2; c++) begin
            @(negedge clk);
            check("mid_place_valid", place_valid, 32'(exp_pv[c]));
            if (place_valid) seen++;
            start  = 1'b0;
            rand_i = 3'(arr_i[c]);
            rand_j = 3'(arr_j[c]);
        end
        check("mid_two_places", seen, 2);
        rst = 1'b0;
        #1;
        check_zero("mid_rst");
        @(negedge clk);
        rst = 1'b1;
        fill_rand(0);
        run_game(7, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b0;
        start     = 1'b0;
        num_ships = '0;
        rand_i    = '0;
        rand_j    = '0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b1;

        fill_const(0, 0); run_game(0, 1'b0);
        fill_const(2, 3); run_game(1, 1'b0);
        fill_const(1, 1); run_game(2, 1'b0);
        fill_const(7, 0); run_game(3, 1'b0);
        fill_const(0, 0); run_game(5, 1'b0);
        fill_const(3, 4); run_game(7, 1'b0);

        run_reset_mid();

        for (int r = 0; r < 15; r++) begin
            fill_rand(r % 3);
            run_game($urandom_range(0, 7), 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_ship_placer.md
# cpu_ship_placer

Sequences the CPU side of the battleship board setup: on a start pulse it draws (i, j) coordinates from the LFSR random coordinate generator, rejects out-of-range or occupied cells, and places 1-cell ships on the 5x5 grid until the requested count is reached. If too many random draws in a row are rejected, it switches to a deterministic row-major scan. The resulting occupancy mask feeds the game logic and the VGA board renderer.

## Interface
- GRID_N, default 5: grid side length; cell index = i*GRID_N + j.
- MAX_SHIPS, default 5: upper clamp on the requested ship count.
- RETRY_LIMIT, default 8: consecutive rejected random draws before fallback scan.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request; honoured only in IDLE.
- num_ships  in  3  ships to place; sampled on start.
- rand_i  in  3  random row from the generator, nominal range 0..4.
- rand_j  in  3  random column from the generator, nominal range 0..4.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at completion.
- place_valid  out  1  one-cycle pulse per placed ship.
- place_i, place_j  out  3  coordinates of the ship placed this cycle.
- board_occ  out  GRID_N*GRID_N  occupancy mask; bit k = cell k occupied.
- ships_placed  out  3  ships placed so far in the current run.

## Operation
- FSM states: IDLE, SAMPLE, CHECK, PLACE, SCAN, DONE.
- IDLE, start=1:
  - Latch target = min(num_ships, MAX_SHIPS).
  - Clear board_occ, ships_placed, retry counter and scan index.
  - If target==0, go to DONE; otherwise go to SAMPLE.
- SAMPLE: register rand_i/rand_j into the candidate; go to CHECK.
- CHECK: the candidate is rejected if i>=GRID_N, j>=GRID_N, or the cell is occupied (plus the guard rule below, when enabled).
  - Accept: go to PLACE.
  - Reject: retry+1. If retry reaches RETRY_LIMIT, go to SCAN with scan index 0; otherwise go back to SAMPLE.
- SCAN: test one cell per cycle, in increasing index order.
  - First acceptable cell becomes the candidate (i=idx/GRID_N, j=idx%GRID_N); go to PLACE.
  - Index GRID_N*GRID_N-1 rejected: go to DONE with ships_placed < target (short run).
- PLACE:
  - Set the board_occ bit, pulse place_valid with the candidate, ships_placed+1, retry=0.
  - If ships_placed+1 == target, go to DONE; otherwise go to SAMPLE.
- DONE: done=1 for exactly this cycle; go to IDLE.
- start while busy is ignored. board_occ and ships_placed hold their values in IDLE until the next start.
- Index arithmetic: cell index is 5 bits wide; i*GRID_N is computed before truncation.

## Timing
- Reset values: state IDLE; busy, done, place_valid = 0; place_i, place_j, ships_placed = 0; board_occ all 0.
- Reset mid-run aborts immediately to these values. A partially built board is not retained.
- Minimum per-ship cost (first draw accepted): 3 cycles (SAMPLE, CHECK, PLACE).
- One ship, first draw free: start at cycle 0; place_valid at cycle 3; done at cycle 4.
- target==0: done at cycle 1.
- A rejected draw costs 2 cycles. Each scanned cell costs 1 cycle.
- busy rises the cycle after start and falls the cycle after done.

## Configuration
- PLACER_ADJ_GUARD_EN:
  - Defined: a candidate is also rejected if any 4-neighbour (up, down, left, right) is occupied. Edge neighbours outside the grid are ignored.
  - Undefined: only the range and occupancy checks apply.
- With the guard enabled, row-major scan always fits 5 ships on a 5x5 grid.

## Structure
- Shared package battleship_pkg:
  - GRID_N and CELLS = 25.
  - enum placer_state_t.
  - function cell_idx(i, j).
- Sub-module placer_cell_check: combinational accept/reject decision from candidate i, j and board_occ. It contains the guard logic under PLACER_ADJ_GUARD_EN. SCAN and CHECK share it.

## Test plan
- num_ships=0, start -> done at cycle 1; board_occ=0; place_valid never asserted.
- num_ships=1, rand=(2,3) -> place_valid at cycle 3 with (2,3); board_occ bit 13 set; done at cycle 4.
- num_ships=2, rand held at (1,1) -> first ship at (1,1); 8 rejects; scan places the second ship at (0,0); ships_placed=2.
- rand=(7,0) constantly, num_ships=3 -> all rejected; scan places ships at cells 0, 1, 2.
- With guard enabled, rand held at (0,0), num_ships=5 -> cells 0, 2, 4, 6, 8 occupied.
- num_ships=7 -> clamped to 5. Reset asserted after the 2nd place_valid -> all outputs zero; a new start rebuilds the board from empty.
